// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared state encoding and width check for the MAC sequencer
package mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Accumulator must hold at least one full product
  function automatic bit widths_ok(input int a_w, input int b_w, input int acc_w);
    return acc_w >= (a_w + b_w);
  endfunction

endpackage

// File: rtl/mac_datapath.sv
// rtl/mac_datapath.sv - multiply, extended add, saturate/wrap and sticky overflow
module mac_datapath
  import mac_pkg::*;
#(
  parameter int A_WIDTH   = 2,
  parameter int B_WIDTH   = 2,
  parameter int ACC_WIDTH = 8,
  parameter int SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 overflow
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;

  logic [P_WIDTH-1:0]   product;
  logic [ACC_WIDTH:0]   sum;

  // Product is exact at A+B bits; the extra sum bit is the carry-out
  always_comb begin
    product = P_WIDTH'(a) * P_WIDTH'(b);
    sum     = (ACC_WIDTH + 1)'(acc) + (ACC_WIDTH + 1)'(product);
  end

  // Clear wins over enable; a carry makes overflow sticky until the next clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      acc      <= '0;
      overflow <= 1'b0;
    end else if (enable) begin
      if (sum[ACC_WIDTH]) begin
        overflow <= 1'b1;
        acc      <= (SATURATE != 0) ? '1 : sum[ACC_WIDTH-1:0];
      end else begin
        acc      <= sum[ACC_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - IDLE/RUN/DONE sequencer around a multiply-accumulate datapath
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int A_WIDTH   = 2,
  parameter int B_WIDTH   = 2,
  parameter int ACC_WIDTH = 8,
  parameter int LEN_WIDTH = 4,
  parameter int SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic                 abort,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);

  if (!widths_ok(A_WIDTH, B_WIDTH, ACC_WIDTH)) begin : g_width_check
    $error("mac_seq_ctrl: ACC_WIDTH must be >= A_WIDTH + B_WIDTH");
  end

  state_t               state;
  logic [LEN_WIDTH-1:0] count;
  logic                 acc_clear;
  logic                 acc_enable;

  // Abort outranks a same-cycle accept, so the aborted sample never reaches the adder
  always_comb begin
    acc_clear  = (state == ST_IDLE) && start;
    acc_enable = (state == ST_RUN) && in_valid && !abort;
  end

  // Sequencer: state, remaining-sample counter and registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      count    <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            count <= len;
            busy  <= 1'b1;
            if (len == '0) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              in_ready <= 1'b0;
            end else begin
              state    <= ST_RUN;
              in_ready <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            state    <= ST_IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end else if (in_valid) begin
            count <= count - LEN_WIDTH'(1);
            if (count == LEN_WIDTH'(1)) begin
              state    <= ST_DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          done     <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          done     <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

  mac_datapath #(
    .A_WIDTH   (A_WIDTH),
    .B_WIDTH   (B_WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .SATURATE  (SATURATE)
  ) u_datapath (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (acc_clear),
    .enable   (acc_enable),
    .a        (a),
    .b        (b),
    .acc      (acc_out),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - bench for mac_seq_ctrl: wide/saturating/wrapping instances vs a sum-based model
module tb_mac_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [3:0] len;
  logic       abort;
  logic [1:0] a;
  logic [1:0] b;
  logic       in_valid;

  logic       rdy0, rdy1, rdy2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;
  logic       ov0, ov1, ov2;
  logic [7:0] acc0;
  logic [5:0] acc1, acc2;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the true unbounded sum plus sequence bookkeeping
  bit m_running;
  bit m_done;
  int m_remaining;
  int m_sum;

  always #5 clk = ~clk;

  mac_seq_ctrl #(.A_WIDTH(2), .B_WIDTH(2), .ACC_WIDTH(8), .LEN_WIDTH(4), .SATURATE(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len), .abort(abort), .a(a), .b(b),
    .in_valid(in_valid), .in_ready(rdy0), .acc_out(acc0), .busy(busy0), .done(done0), .overflow(ov0));

  mac_seq_ctrl #(.A_WIDTH(2), .B_WIDTH(2), .ACC_WIDTH(6), .LEN_WIDTH(4), .SATURATE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len), .abort(abort), .a(a), .b(b),
    .in_valid(in_valid), .in_ready(rdy1), .acc_out(acc1), .busy(busy1), .done(done1), .overflow(ov1));

  mac_seq_ctrl #(.A_WIDTH(2), .B_WIDTH(2), .ACC_WIDTH(6), .LEN_WIDTH(4), .SATURATE(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len), .abort(abort), .a(a), .b(b),
    .in_valid(in_valid), .in_ready(rdy2), .acc_out(acc2), .busy(busy2), .done(done2), .overflow(ov2));

  function automatic int exp_acc(input int s, input int w, input bit sat);
    int lim;
    lim = (1 << w) - 1;
    if (s > lim) return sat ? lim : (s % (1 << w));
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rdy0", 32'(rdy0), 32'(m_running));
    chk("busy0", 32'(busy0), 32'(m_running | m_done));
    chk("done0", 32'(done0), 32'(m_done));
    chk("acc0", 32'(acc0), exp_acc(m_sum, 8, 1'b1));
    chk("ov0", 32'(ov0), 32'(m_sum > 255));
    chk("rdy1", 32'(rdy1), 32'(m_running));
    chk("done1", 32'(done1), 32'(m_done));
    chk("acc1", 32'(acc1), exp_acc(m_sum, 6, 1'b1));
    chk("ov1", 32'(ov1), 32'(m_sum > 63));
    chk("busy2", 32'(busy2), 32'(m_running | m_done));
    chk("done2", 32'(done2), 32'(m_done));
    chk("acc2", 32'(acc2), exp_acc(m_sum, 6, 1'b0));
    chk("ov2", 32'(ov2), 32'(m_sum > 63));
  endtask

  task automatic model_reset();
    m_running   = 1'b0;
    m_done      = 1'b0;
    m_remaining = 0;
    m_sum       = 0;
  endtask

  // Advance the model by one clock using the inputs that were presented before the edge
  task automatic model_clock(input bit st, input int ln, input bit ab, input bit iv, input int av, input int bv);
    bit was_done;
    was_done = m_done;
    m_done   = 1'b0;
    if (was_done) begin
      // single done cycle, back to idle
    end else if (!m_running) begin
      if (st) begin
        m_sum       = 0;
        m_remaining = ln;
        if (ln == 0) m_done = 1'b1;
        else m_running = 1'b1;
      end
    end else if (ab) begin
      m_running = 1'b0;
    end else if (iv) begin
      m_sum       = m_sum + av * bv;
      m_remaining = m_remaining - 1;
      if (m_remaining == 0) begin
        m_running = 1'b0;
        m_done    = 1'b1;
      end
    end
  endtask

  task automatic step(input bit st, input int ln, input bit ab, input bit iv, input int av, input int bv);
    start    = st;
    len      = 4'(ln);
    abort    = ab;
    in_valid = iv;
    a        = 2'(av);
    b        = 2'(bv);
    @(posedge clk);
    model_clock(st, ln, ab, iv, av, bv);
    #1;
    check_all();
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    len      = '0;
    abort    = 1'b0;
    a        = '0;
    b        = '0;
    in_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset_n = 1'b1;

    // Default sequence: (1,2),(3,3),(2,1) -> 2, 11, 13 then done
    step(1, 3, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 2);
    chk("def_acc_1", 32'(acc0), 2);
    step(0, 0, 0, 1, 3, 3);
    chk("def_acc_2", 32'(acc0), 11);
    step(0, 0, 0, 1, 2, 1);
    chk("def_acc_3", 32'(acc0), 13);
    chk("def_done", 32'(done0), 1);
    step(0, 0, 0, 0, 0, 0);

    // Handshake gaps
    step(1, 2, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3, 2);
    chk("gap_acc_a", 32'(acc0), 6);
    step(0, 0, 0, 0, 3, 3);
    step(0, 0, 0, 0, 2, 1);
    chk("gap_hold", 32'(acc0), 6);
    step(0, 0, 0, 1, 1, 1);
    chk("gap_acc_b", 32'(acc0), 7);
    step(0, 0, 0, 0, 0, 0);

    // Saturate / wrap: eight products of 9
    step(1, 8, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 3, 3);
    chk("sat_acc", 32'(acc1), 63);
    chk("sat_ov", 32'(ov1), 1);
    chk("wrap_acc", 32'(acc2), 8);
    chk("wrap_ov", 32'(ov2), 1);
    chk("wide_acc", 32'(acc0), 72);
    step(0, 0, 0, 0, 0, 0);

    // Start in RUN ignored, abort beats a same-cycle accept
    step(1, 4, 0, 0, 0, 0);
    step(1, 1, 0, 1, 2, 2);
    step(0, 0, 0, 1, 2, 2);
    step(0, 0, 1, 1, 3, 3);
    chk("abort_acc", 32'(acc0), 8);
    chk("abort_rdy", 32'(rdy0), 0);
    chk("abort_done", 32'(done0), 0);

    // Zero length sequence
    step(1, 0, 0, 0, 0, 0);
    chk("zero_done", 32'(done0), 1);
    chk("zero_acc", 32'(acc0), 0);
    step(1, 3, 1, 1, 1, 1);
    chk("done_ignores_start", 32'(busy0), 0);
    step(0, 0, 0, 0, 0, 0);

    // Async reset mid-RUN with acc = 5
    step(1, 4, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 2);
    step(0, 0, 0, 1, 1, 3);
    chk("pre_rst_acc", 32'(acc0), 5);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_acc", 32'(acc0), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_rdy", 32'(rdy0), 0);
    check_all();
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 0, 0, 1, 3, 3);
    step(0, 0, 0, 1, 3, 3);
    chk("idle_ignores_valid", 32'(acc0), 0);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 15), $urandom_range(0, 19) == 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
Parametrised successor to the fixed 2-bit MAC-plus-FSM pairing. It accumulates a programmable-length sequence of unsigned A×B products under an integrated IDLE/RUN/DONE controller.
- Generalised operand and accumulator widths.
- valid/ready input handshake with back-pressure-safe acceptance.
- Programmable sample count, with a done pulse at the end.
- Selectable saturate or wrap arithmetic, with a sticky overflow flag.
- Abort input.
It sits between an operand source (streaming a,b pairs) and a result consumer.

Parameters:
A_WIDTH, 2, width of unsigned operand a
B_WIDTH, 2, width of unsigned operand b
ACC_WIDTH, 8, accumulator/result width; must be >= A_WIDTH+B_WIDTH (elaboration error otherwise)
LEN_WIDTH, 4, width of sample-count input len
SATURATE, 1, 1 = clamp accumulator at all-ones on overflow; 0 = wrap modulo 2^ACC_WIDTH

Ports:
clk  input  1  system clock, rising-edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  begin a new accumulation (sampled in IDLE only)
len  input  LEN_WIDTH  number of products to accumulate, latched on start
abort  input  1  terminate RUN, return to IDLE without done
a  input  A_WIDTH  unsigned operand
b  input  B_WIDTH  unsigned operand
in_valid  input  1  a,b valid this cycle
in_ready  output  1  block accepts a,b this cycle
acc_out  output  ACC_WIDTH  accumulator value (registered)
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse when sequence completes
overflow  output  1  sticky: set if any add in current sequence exceeded ACC_WIDTH

Behaviour:
- Reset (reset_n=0, asynchronous, immediate):
  - state=IDLE.
  - acc_out=0, overflow=0, done=0, busy=0, in_ready=0.
  - Internal counter=0.
  - Reset asserted mid-RUN discards the sequence; no done pulse.
- IDLE:
  - in_ready=0, busy=0.
  - start=1 → acc_out<=0, overflow<=0, count<=len.
  - If len==0 → next state DONE (zero-length sequence; acc_out=0); else → RUN.
  - acc_out holds the previous result until the next start.
- RUN:
  - in_ready=1 (combinational from state only, not from in_valid).
  - Accept occurs when in_valid && in_ready.
  - On accept: product = a*b, zero-extended to ACC_WIDTH; sum = acc_out + product computed at ACC_WIDTH+1 bits.
  - If the carry is set: overflow<=1 and acc_out<=all-ones (SATURATE=1) or sum[ACC_WIDTH-1:0] (SATURATE=0).
  - count decrements on accept. Accepting the final sample (count==1) → DONE.
  - No accept (in_valid=0): all registers hold.
  - start in RUN is ignored.
  - abort=1 → IDLE next cycle. acc_out and overflow hold their partial values; no done. abort has priority over a same-cycle accept, so that sample is not accumulated.
- DONE:
  - Lasts exactly one cycle: done=1, busy=1, in_ready=0.
  - Unconditional → IDLE.
  - abort and start are ignored in DONE.
- Latency:
  - acc_out reflects an accepted sample on the next rising edge.
  - done asserts the cycle after the final accept.
  - Minimum sequence of len=N with in_valid held high: start cycle + N RUN cycles + 1 DONE cycle.
- Back-to-back sequences: start asserted in the cycle after DONE (state is IDLE) begins a new sequence.

Decomposition:
- Shared package mac_pkg holds:
  - State encoding localparams: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - The width-check helper constant used by the elaboration assertion.
- Natural sub-module mac_datapath (parametrised on A_WIDTH, B_WIDTH, ACC_WIDTH, SATURATE):
  - multiply, extended add, saturate/wrap select.
  - acc register with clear and enable inputs.
  - overflow flag.
- mac_seq_ctrl holds the FSM and counter and drives the clear/enable of mac_datapath.

Test Plan:
- Defaults. start, len=3; a,b pairs (1,2),(3,3),(2,1) with in_valid held high → acc_out 2,11,13 on successive edges; done pulses once the cycle after the third accept; overflow=0; then IDLE.
- Handshake gaps. len=2, in_valid toggling 1,0,0,1 with (3,2),(x,x),(x,x),(1,1) → acc_out=6 after the first accept, held through the gaps, 7 after the second; done one cycle later.
- Saturation. ACC_WIDTH=6, SATURATE=1, len=8, a=3, b=3 for all samples → after 7 accepts acc=63 (true sum 63); 8th accept → acc_out=63, overflow=1, done pulses.
- Wrap. Same stimulus with SATURATE=0 → final acc_out=8 (72 mod 64), overflow=1.
- Abort and zero length:
  - len=4; after 2 accepts of (2,2) assert abort together with in_valid → acc_out=8 held, no done, IDLE next cycle, in_ready=0.
  - Then start with len=0 → acc_out=0, done pulses the following cycle.
- Async reset. Mid-RUN (acc_out=5), pull reset_n low between clock edges → acc_out=0, busy=0, in_ready=0 immediately, without waiting for a clock edge; after release, IDLE ignores in_valid until start.
